demux_stream_reg: RTL
=====================

Name: demux_stream_reg

Overview:
- Parametrised, registered successor to the team's 1-to-8 combinational demultiplexer.
- Routes a DATA_W-bit input word to one of N output lanes selected by s.
- Uses a valid/ready handshake on the input and on every output lane.
- Each lane has a one-entry holding register, so a stalled lane does not corrupt the other lanes.
- Sits between a single producer and N independent consumers, for example a per-unit command fan-out.

Parameters:
- N, 8, number of output lanes (2..32).
- DATA_W, 8, width of each data word.
- SEL_W, $clog2(N), width of the select input.
- ZERO_IDLE, 1, when 1 a lane's y data reads 0 whenever its y_valid is 0; when 0 the last value is held.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- en  in  1  global enable; when low, no new input is accepted.
- a  in  DATA_W  input data word.
- a_valid  in  1  input word present.
- a_ready  out  1  block can accept a this cycle.
- s  in  SEL_W  destination lane index, sampled with a.
- y  out  N*DATA_W  lane data, flat; lane i occupies bits [i*DATA_W +: DATA_W].
- y_valid  out  N  per-lane data valid.
- y_ready  in  N  per-lane consumer ready.
- err  out  1  one-cycle pulse when a word with an out-of-range s is accepted and dropped.
- busy  out  1  OR of all y_valid bits.

Behaviour:
- Reset (async assert, sync release): all lane registers = 0, y_valid = 0, err = 0, busy = 0. a_ready follows the combinational rule below and is 0 while en = 0.
- Input acceptance:
  - A transfer occurs when a_valid & a_ready.
  - a_ready is combinational: en & (s >= N ? 1 : (!y_valid[s] | y_ready[s])).
  - a_ready depends on y_ready[s] (pass-through), which gives full throughput on a lane that is drained every cycle.
- Latency: an accepted word appears on lane s with y_valid[s] = 1 on the next rising edge. Latency is 1 cycle.
- Lane register, per lane i:
  - Load when a transfer occurs with s = i.
  - y_valid[i] is set on load.
  - Otherwise y_valid[i] clears when y_valid[i] & y_ready[i].
  - Load and drain in the same cycle: the new word replaces the old one and y_valid stays 1.
  - While y_valid[i] = 1 and y_ready[i] = 0, the data is held stable and must not change.
- Lane states: EMPTY (y_valid = 0) and FULL (y_valid = 1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or when stalled.
- Out-of-range select (s >= N, only possible when N is not a power of two):
  - The word is accepted (a_ready = en), discarded, and err = 1 for exactly the following cycle.
  - No lane changes state.
- en low: a_ready = 0. Words already in lanes still drain normally. en has no effect on y_valid.
- ZERO_IDLE = 1: the y lane output is gated to 0 when its y_valid is 0, matching the zero-fill of the earlier block.
- Simultaneous events: only one lane can load per cycle. Any number of lanes may drain in the same cycle.
- Reset mid-operation: all held words are lost, y_valid goes to 0 immediately (asynchronously), and nothing is replayed.
- Protocol: once a_valid is asserted, a, s and a_valid must stay stable until the transfer completes. The bench asserts this; the RTL does not check it.

Decomposition:
- Shared package demux_pkg:
  - Function sel_width(N) returning $clog2(N), with a minimum of 1.
  - Constant DEMUX_MAX_LANES = 32.
- One natural sub-module, demux_slot: the single-lane holding register (load, drain, valid, zero gating), instantiated N times in a generate loop.
- The top level holds the a_ready mux, the range check and the err register.

Test Plan:
- Reset and idle (N=8, DATA_W=8): drive rst_n = 0 with a_valid = 1 -> y = 0, y_valid = 0, err = 0. After release with en = 0 -> a_ready = 0 and no lane loads.
- Single routing: en = 1, a = 8'hA5, s = 3, all y_ready = 1 for one cycle -> the next cycle y_valid = 8'b0000_1000 and lane 3 = 8'hA5. The cycle after -> y_valid = 0, and lane 3 reads 0 with ZERO_IDLE = 1.
- Back-pressure: hold y_ready[5] = 0 and send 8'h11 then 8'h22 to s = 5:
  - First word -> lane 5 = 8'h11, FULL.
  - Second word -> a_ready = 0 and the word is held.
  - Raise y_ready[5] -> 8'h11 consumed, the same cycle a_ready = 1, and 8'h22 appears next cycle.
- Lane independence: lane 2 stalled FULL, then send 8'h33 to s = 6 -> accepted immediately, and lane 2 data is unchanged.
- Out-of-range (N=6, SEL_W=3): s = 7, a = 8'hFF -> a_ready = 1, err pulses for one cycle, y_valid stays 0.
- Throughput and reset: stream 16 words round-robin over s = 0..7 with all ready -> one transfer per cycle and in-order data per lane. Assert rst_n low mid-stream -> y_valid = 0 asynchronously.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered stream demultiplexer: lane state encoding,
// the lane-count ceiling and the select-width helper.
package demux_pkg;

    localparam int DEMUX_MAX_LANES = 32;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output lane: a single-entry holding register with valid/ready drain and
// optional zero gating of the data while the lane is empty.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              ready,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    lane_state_e       state_reg;
    lane_state_e       state_next;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LANE_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // load is only raised when the lane is empty or draining, so a stalled word never changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= d;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LANE_EMPTY: if (load)           state_next = LANE_FULL;
            LANE_FULL:  if (!load && ready) state_next = LANE_EMPTY;
            default:                        state_next = LANE_EMPTY;
        endcase
    end

    assign valid = (state_reg == LANE_FULL);
    assign q     = (ZERO_IDLE && !valid) ? '0 : data_reg;

endmodule

// File: rtl/demux_stream_reg.sv
// Registered 1-to-N stream demultiplexer: routes a word to lane s under valid/ready,
// drops out-of-range selects with a one-cycle err pulse.
module demux_stream_reg
    import demux_pkg::*;
#(
    parameter int N         = 8,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = sel_width(N),
    parameter int ZERO_IDLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DATA_W-1:0]   a,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [SEL_W-1:0]    s,
    output logic [N*DATA_W-1:0] y,
    output logic [N-1:0]        y_valid,
    input  logic [N-1:0]        y_ready,
    output logic                err,
    output logic                busy
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic [N-1:0]        lane_free;
    logic [N-1:0]        load_vec;
    logic [SEL_SPAN-1:0] free_ext;
    logic                sel_oob;
    logic                xfer;
    logic                err_reg;

    assign sel_oob   = (int'(s) >= N);
    assign lane_free = ~y_valid | y_ready;

    // Pad the free vector to the full select range so s can index it without bounds issues
    always_comb begin
        free_ext          = '0;
        free_ext[N-1:0]   = lane_free;
    end

    assign a_ready = en & (sel_oob | free_ext[s]);
    assign xfer    = a_valid & a_ready;

    always_comb begin
        load_vec = '0;
        for (int i = 0; i < N; i++) begin
            load_vec[i] = xfer && (int'(s) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= xfer & sel_oob;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            demux_slot #(
                .DATA_W    (DATA_W),
                .ZERO_IDLE (ZERO_IDLE != 0)
            ) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load_vec[gi]),
                .d     (a),
                .ready (y_ready[gi]),
                .q     (y[gi*DATA_W +: DATA_W]),
                .valid (y_valid[gi])
            );
        end
    endgenerate

    assign err  = err_reg;
    assign busy = |y_valid;

endmodule
